sync_up_event_counter: RTL and testbench
========================================

# sync_up_event_counter

Synchronous modulo-N up counter that counts rising edges of an asynchronous event input, running on a single free-running system clock. It is the count-up counterpart of the team's ripple down counter. Every flop shares one clock edge, so there are no ripple clocks. It is used wherever event counts must be read glitch-free in the system clock domain. It adds synchronous load, enable, terminal-count, wrap-carry and sticky overflow for cascading and software polling.

## Interface
- WIDTH, 3, counter width in bits
- MODULUS, 8, count range 0..MODULUS-1; legal range 2..2^WIDTH
- SYNC_STAGES, 2, synchronizer depth for evt; minimum 2
- clk  in  1  system clock; all flops update on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  count enable; gates increments only, not load
- evt  in  1  asynchronous event input; each rising edge is one count
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value loaded when load=1
- clr_ovf  in  1  clears the sticky overflow flag
- q  out  WIDTH  current count
- tc  out  1  terminal count, q == MODULUS-1 (decoded from the q register)
- carry  out  1  one-cycle pulse on wrap MODULUS-1 -> 0
- ovf  out  1  sticky wrap flag

## Operation
- evt passes through a SYNC_STAGES flop chain: s[0] .. s[SYNC_STAGES-1].
- One extra flop, s_prev, holds the previous value of s[SYNC_STAGES-1].
- Edge detect: inc = s[SYNC_STAGES-1] & ~s_prev. Falling edges are ignored.
- Priority per cycle: rst > load > (inc & en) > hold.
- Load:
  - q <= load_val if load_val < MODULUS, else q <= 0.
  - A coincident inc is dropped, not deferred.
  - carry = 0 on a load cycle.
- Increment when inc & en:
  - If q == MODULUS-1: q <= 0, carry <= 1 for one cycle, ovf <= 1.
  - Else: q <= q + 1 and carry <= 0.
- en = 0: detected edges are discarded, not queued. The synchronizer and s_prev keep running.
- ovf:
  - Set by every wrap.
  - Cleared by clr_ovf.
  - If a wrap and clr_ovf coincide, set wins and ovf stays 1.
- carry is 0 on every cycle without a wrap.
- Reset values:
  - q = 0, carry = 0, ovf = 0, tc = 0 when MODULUS > 1.
  - All sync stages and s_prev = 1. This preset means evt held high through reset release is not counted as an edge. evt held low produces no edge either.
- Reset mid-operation: takes effect at the next rising clk edge. Pending synchronized edges are flushed.

## Timing
- Latency: evt rises before clk edge N (meeting setup) -> q changes at edge N+SYNC_STAGES. With default depth 2, q is visible after edge N+2.
- If evt violates setup at edge N, the edge may land one cycle later (N+SYNC_STAGES+1). It is never lost and never double-counted.
- evt must stay high for at least 2 clk cycles and low for at least 2 clk cycles. Otherwise the edge may be missed.
- Maximum count rate: one increment per 4 clk cycles.
- Load latency: load sampled at edge M -> q = load_val after edge M. tc updates in the same cycle as q.
- carry and ovf assert after the same edge that makes q = 0 on wrap.
- clr_ovf sampled at edge M -> ovf = 0 after edge M.

## Test plan
- Reset release:
  - Stimulus: rst=1 for 3 cycles with evt=1, then rst=0 with evt held 1 for 10 cycles.
  - Required: q=0, carry=0, ovf=0, tc=0 throughout; no count.
- Basic count and wrap (WIDTH=3, MODULUS=8):
  - Stimulus: 9 evt pulses, each 3 cycles high / 3 cycles low, en=1.
  - Required: q steps 1..7 then 0, then 1. Each step occurs exactly 2 edges after evt rises.
  - Required: tc=1 only while q=7. carry is a single 1-cycle pulse at 7->0. ovf=1 from then on.
- MODULUS=5:
  - Stimulus: load load_val=4, then 1 evt.
  - Required: q=0 with carry pulse.
  - Stimulus: load load_val=6.
  - Required: q=0.
- Load/increment collision:
  - Stimulus: q=2; assert load=1 with load_val=6 in the same cycle inc would fire.
  - Required: q=6; the edge is dropped (q stays 6 afterwards); carry=0.
- Enable gating:
  - Stimulus: en=0 during 3 evt pulses, then en=1 for 1 pulse, starting from q=3.
  - Required: q=3 held during the gated pulses, then q=4.
- Sticky flag collision:
  - Stimulus: clr_ovf=1 on the same cycle as a wrap.
  - Required: ovf=1.
  - Stimulus: clr_ovf=1 on a later cycle with no wrap.
  - Required: ovf=0 after that edge.
- Mid-count reset:
  - Stimulus: assert rst one cycle after an evt rise.
  - Required: q=0 and no increment appears after rst deasserts.

Source files
------------

// File: rtl/sync_up_event_counter_if.sv
// Bus interface for sync_up_event_counter.
//   master: drives en, evt, load, load_val, clr_ovf; observes q, tc, carry, ovf
//   slave : the counter side of the same signals
interface sync_up_event_counter_if #(
   parameter int unsigned WIDTH = 3
);
   logic             en;
   logic             evt;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr_ovf;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             carry;
   logic             ovf;

   modport master (
      output en, evt, load, load_val, clr_ovf,
      input  q, tc, carry, ovf
   );

   modport slave (
      input  en, evt, load, load_val, clr_ovf,
      output q, tc, carry, ovf
   );
endinterface

// File: rtl/sync_up_event_counter.sv
// Synchronous modulo-MODULUS up counter of rising edges on an asynchronous
// event input, with load, enable, terminal count, wrap carry and sticky
// overflow. All flops are clocked by clk; rst is synchronous, active-high.
// Ports:
//   clk, rst      : system clock and reset
//   bus.en        : count enable (gates increments only)
//   bus.evt       : asynchronous event input, one count per rising edge
//   bus.load      : synchronous load strobe, bus.load_val is the value
//   bus.clr_ovf   : clears the sticky overflow flag
//   bus.q         : current count
//   bus.tc        : high while q == MODULUS-1
//   bus.carry     : one-cycle pulse on wrap MODULUS-1 -> 0
//   bus.ovf       : sticky wrap flag
module sync_up_event_counter #(
   parameter int unsigned WIDTH       = 3,
   parameter int unsigned MODULUS     = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic                    clk,
   input logic                    rst,
   sync_up_event_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_prev;
   logic                   inc_c;
   logic                   load_ok_c;

   logic [WIDTH-1:0] q_r, q_nxt;
   logic             tc_r;
   logic             carry_r, carry_nxt;
   logic             ovf_r, ovf_nxt;

   // Synchronizer and edge-history flop; preset to 1 so a high evt at
   // reset release does not look like a rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         s_prev <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.evt};
         s_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign inc_c     = sync_q[SYNC_STAGES-1] & ~s_prev;
   assign load_ok_c = (32'(bus.load_val) < MODULUS);

   // Next-state: load beats increment; a wrap beats clr_ovf.
   always_comb begin
      q_nxt     = q_r;
      carry_nxt = 1'b0;
      ovf_nxt   = ovf_r;
      if (bus.clr_ovf) ovf_nxt = 1'b0;
      if (bus.load) begin
         q_nxt = load_ok_c ? bus.load_val : '0;
      end else if (inc_c && bus.en) begin
         if (q_r == MAX_CNT) begin
            q_nxt     = '0;
            carry_nxt = 1'b1;
            ovf_nxt   = 1'b1;
         end else begin
            q_nxt = q_r + WIDTH'(1);
         end
      end
   end

   // Count/status registers; tc is registered from q_nxt so it tracks q.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r     <= '0;
         tc_r    <= 1'b0;
         carry_r <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         q_r     <= q_nxt;
         tc_r    <= (q_nxt == MAX_CNT);
         carry_r <= carry_nxt;
         ovf_r   <= ovf_nxt;
      end
   end

   assign bus.q     = q_r;
   assign bus.tc    = tc_r;
   assign bus.carry = carry_r;
   assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_sync_up_event_counter.sv
// Bench for sync_up_event_counter: a MODULUS=8 and a MODULUS=5 instance
// share one stimulus stream and are checked every cycle against a model
// that works from the sampled evt history rather than the flop chain.
module tb_sync_up_event_counter;
   localparam int unsigned W    = 3;
   localparam int unsigned S    = 2;
   localparam int          HIST = 8192;

   logic clk = 1'b0;
   logic rst;
   logic en, evt, load, clr_ovf;
   logic [W-1:0] load_val;

   int compared   = 0;
   int mismatched = 0;

   sync_up_event_counter_if #(.WIDTH(W)) bus8 ();
   sync_up_event_counter_if #(.WIDTH(W)) bus5 ();

   assign bus8.en = en;   assign bus8.evt = evt;   assign bus8.load = load;
   assign bus8.load_val = load_val;                assign bus8.clr_ovf = clr_ovf;
   assign bus5.en = en;   assign bus5.evt = evt;   assign bus5.load = load;
   assign bus5.load_val = load_val;                assign bus5.clr_ovf = clr_ovf;

   sync_up_event_counter #(.WIDTH(W), .MODULUS(8), .SYNC_STAGES(S)) dut8 (
      .clk(clk), .rst(rst), .bus(bus8.slave));
   sync_up_event_counter #(.WIDTH(W), .MODULUS(5), .SYNC_STAGES(S)) dut5 (
      .clk(clk), .rst(rst), .bus(bus5.slave));

   always #5 clk = ~clk;

   // Reference model state
   bit ev_hist [HIST];
   int cyc      = 0;
   int last_rst = -1;
   int mod_v [2] = '{8, 5};
   int mq    [2];
   int mcar  [2];
   int movf  [2];

   // evt as seen at edge k; anything up to the last reset edge reads as 1.
   function automatic bit eff(int k);
      if (k < 0 || k <= last_rst) return 1'b1;
      return ev_hist[k];
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      bit inc;
      @(posedge clk);
      if (cyc >= HIST) begin
         $display("FAIL history_bound: observed cycle %0d expected below %0d", cyc, HIST);
         $fatal(1, "history overflow");
      end
      ev_hist[cyc] = evt;
      // A rise sampled at edge k is counted at edge k+S.
      inc = eff(cyc - S) & ~eff(cyc - S - 1);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            mq[i] = 0; mcar[i] = 0; movf[i] = 0;
         end else begin
            mcar[i] = 0;
            if (clr_ovf) movf[i] = 0;
            if (load) begin
               mq[i] = (int'(load_val) < mod_v[i]) ? int'(load_val) : 0;
            end else if (inc && en) begin
               if (mq[i] == mod_v[i] - 1) begin
                  mq[i] = 0; mcar[i] = 1; movf[i] = 1;
               end else begin
                  mq[i] = mq[i] + 1;
               end
            end
         end
      end
      if (rst) last_rst = cyc;
      cyc++;
      #1;
      check("q8",     32'(bus8.q),     32'(mq[0]));
      check("tc8",    32'(bus8.tc),    32'(mq[0] == 7));
      check("carry8", 32'(bus8.carry), 32'(mcar[0]));
      check("ovf8",   32'(bus8.ovf),   32'(movf[0]));
      check("q5",     32'(bus5.q),     32'(mq[1]));
      check("tc5",    32'(bus5.tc),    32'(mq[1] == 4));
      check("carry5", 32'(bus5.carry), 32'(mcar[1]));
      check("ovf5",   32'(bus5.ovf),   32'(movf[1]));
   endtask

   task automatic ticks(int n);
      repeat (n) tick();
   endtask

   task automatic pulse(int hi, int lo);
      evt = 1'b1; ticks(hi);
      evt = 1'b0; ticks(lo);
   endtask

   task automatic do_load(logic [W-1:0] v);
      load = 1'b1; load_val = v; tick();
      load = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; en = 1'b1; evt = 1'b1; load = 1'b0; load_val = '0; clr_ovf = 1'b0;

      // Reset release with evt held high: no count
      ticks(3);
      rst = 1'b0;
      ticks(10);
      check("rst_rel_q8", 32'(bus8.q), 32'd0);
      check("rst_rel_q5", 32'(bus5.q), 32'd0);
      evt = 1'b0; ticks(3);

      // Basic count and wrap
      repeat (9) pulse(3, 3);
      check("wrap_q8",   32'(bus8.q),   32'd1);
      check("wrap_ovf8", 32'(bus8.ovf), 32'd1);
      check("wrap_q5",   32'(bus5.q),   32'd4);

      // MODULUS=5 wrap from loaded 4, then out-of-range load
      do_load(3'd4);
      check("m5_ld4_tc", 32'(bus5.tc), 32'd1);
      evt = 1'b1; ticks(3);
      check("m5_wrap_q",     32'(bus5.q),     32'd0);
      check("m5_wrap_carry", 32'(bus5.carry), 32'd1);
      tick();
      check("m5_carry_end", 32'(bus5.carry), 32'd0);
      evt = 1'b0; ticks(3);
      do_load(3'd6);
      check("m5_ld6_q5", 32'(bus5.q), 32'd0);
      check("m5_ld6_q8", 32'(bus8.q), 32'd6);
      ticks(2);

      // Load / increment collision: edge is dropped
      do_load(3'd2);
      evt = 1'b1; ticks(2);
      load = 1'b1; load_val = 3'd6; tick();
      load = 1'b0;
      check("coll_q8",     32'(bus8.q),     32'd6);
      check("coll_carry8", 32'(bus8.carry), 32'd0);
      ticks(4);
      check("coll_hold_q8", 32'(bus8.q), 32'd6);
      evt = 1'b0; ticks(3);

      // Enable gating
      do_load(3'd3);
      en = 1'b0;
      repeat (3) pulse(3, 3);
      check("en_gated_q8", 32'(bus8.q), 32'd3);
      en = 1'b1;
      pulse(3, 3);
      check("en_count_q8", 32'(bus8.q), 32'd4);

      // Sticky overflow: clear, then wrap coinciding with clear, then clear
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      check("clr_ovf8", 32'(bus8.ovf), 32'd0);
      do_load(3'd7);
      evt = 1'b1; ticks(2);
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      check("setwin_ovf8", 32'(bus8.ovf),   32'd1);
      check("setwin_car8", 32'(bus8.carry), 32'd1);
      ticks(2);
      evt = 1'b0; ticks(3);
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      check("late_clr_ovf8", 32'(bus8.ovf), 32'd0);

      // Mid-count reset flushes the pending edge
      do_load(3'd1);
      ticks(2);
      evt = 1'b1; tick();
      rst = 1'b1; tick();
      rst = 1'b0;
      ticks(5);
      check("midrst_q8", 32'(bus8.q), 32'd0);
      check("midrst_q5", 32'(bus5.q), 32'd0);
      evt = 1'b0; ticks(3);

      // Randomized traffic against the model
      repeat (100) begin
         evt = ~evt;
         n = $urandom_range(2, 6);
         repeat (n) begin
            en       = ($urandom_range(0, 7) != 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = W'($urandom_range(0, 7));
            clr_ovf  = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            tick();
         end
      end
      rst = 1'b0; load = 1'b0; clr_ovf = 1'b0; en = 1'b1; evt = 1'b0;
      ticks(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
